// File: rtl/calcn_core.sv
// calcn_core: NUM_PORTS two-beat request ports sharing one round-robin arbitrated ALU
module calcn_core #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                         c_clk,
  input  logic                         reset,
  input  logic [0:4*NUM_PORTS-1]       req_cmd_in,
  input  logic [0:DATA_W*NUM_PORTS-1]  req_data_in,
  output logic [0:2*NUM_PORTS-1]       out_resp,
  output logic [0:DATA_W*NUM_PORTS-1]  out_data
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int SW = $clog2(DATA_W);
  localparam logic [1:0] IDLE = 2'd0, OP2 = 2'd1, PEND = 2'd2;
  logic [1:0] st [NUM_PORTS];
  logic [3:0] cmd_q [NUM_PORTS];
  logic [DATA_W-1:0] op1_q [NUM_PORTS];
  logic [DATA_W-1:0] op2_q [NUM_PORTS];
  logic [PW-1:0] ptr, gnt;
  logic gnt_v, bad;
  logic [3:0] c;
  logic [DATA_W-1:0] a, b, res_data;
  logic [DATA_W:0] sum;
  logic [1:0] res_resp;
  // scan from ptr upward; descending loop lets the nearest pending port win
  always_comb begin
    int j;
    gnt_v = 1'b0;
    gnt = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (st[j] == PEND) begin
        gnt_v = 1'b1;
        gnt = PW'(j);
      end
    end
  end
  assign c = cmd_q[gnt];
  assign a = op1_q[gnt];
  assign b = op2_q[gnt];
  assign sum = {1'b0, a} + {1'b0, b};
  always_comb begin
    bad = !(c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6) || (c == 4'd1 && sum[DATA_W]) || (c == 4'd2 && b > a);
    res_resp = bad ? 2'd2 : 2'd1;
    res_data = c == 4'd1 ? (sum[DATA_W] ? {DATA_W{SATURATE}} : sum[DATA_W-1:0]) :
               (c == 4'd2 && !bad) ? a - b :
               c == 4'd5 ? a << b[SW-1:0] :
               c == 4'd6 ? a >> b[SW-1:0] : '0;
  end
  always_ff @(posedge c_clk) begin
    if (reset) begin
      ptr <= '0;
      out_resp <= '0;
      out_data <= '0;
      for (int p = 0; p < NUM_PORTS; p++) st[p] <= IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_resp[2*p +: 2] <= (gnt_v && gnt == PW'(p)) ? res_resp : 2'd0;
        out_data[DATA_W*p +: DATA_W] <= (gnt_v && gnt == PW'(p)) ? res_data : '0;
        if (st[p] == IDLE && req_cmd_in[4*p +: 4] != 4'd0) begin
          st[p] <= OP2;
          cmd_q[p] <= req_cmd_in[4*p +: 4];
          op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
        end else if (st[p] == OP2) begin
          st[p] <= PEND;
          op2_q[p] <= req_data_in[DATA_W*p +: DATA_W];
        end else if (st[p] == PEND && gnt_v && gnt == PW'(p)) begin
          st[p] <= IDLE;
        end
      end
      if (gnt_v) ptr <= (int'(gnt) == NUM_PORTS - 1) ? '0 : gnt + 1'b1;
    end
  end
endmodule

// File: doc/calcn_core.md
# calcn_core

Parametrised successor to the four-port calc1 calculator core. It has NUM_PORTS independent two-beat request ports, each with a DATA_W-bit datapath, sharing one ALU through a round-robin arbiter. It keeps the calc1 command/response encoding and adds an optional saturating overflow mode. It sits between the request-port drivers and the response consumers in the calculator subsystem.

## Interface
- NUM_PORTS, 4: number of request/response ports, 1..16.
- DATA_W, 32: operand/result width; power of two, at least 8.
- SATURATE, 0: 0 = overflow/underflow returns data 0; 1 = data is clamped.
- c_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_cmd_in  in  [0:4*NUM_PORTS-1]  command for port p is bits 4p..4p+3; lowest index is the MSB.
- req_data_in  in  [0:DATA_W*NUM_PORTS-1]  operand for port p is bits DATA_W*p..DATA_W*p+DATA_W-1; lowest index is the MSB.
- out_resp  out  [0:2*NUM_PORTS-1]  response for port p is bits 2p..2p+1.
- out_data  out  [0:DATA_W*NUM_PORTS-1]  result for port p; same slicing as req_data_in.

## Operation
- Commands:
  - 0 nop.
  - 1 add.
  - 2 sub (op1 − op2).
  - 5 shift left logical.
  - 6 shift right logical. The shift amount is the low log2(DATA_W) bits of op2.
  - All other values are invalid.
- Responses:
  - 0 none.
  - 1 success.
  - 2 overflow, underflow or invalid command.
  - 3 reserved; never driven.
- Per-port FSM has three states: IDLE, OP2, PEND.
  - IDLE: a nonzero cmd captures cmd and op1 → OP2.
  - OP2: captures op2; cmd is ignored this cycle → PEND.
  - PEND: waits for a grant. When granted, the result is registered and the port → IDLE.
  - While in OP2 or PEND, a nonzero cmd is discarded. No response is produced for it, and the in-flight request is unaffected.
- Arbiter:
  - One grant per cycle among PEND ports, round-robin.
  - Pointer is 0 after reset. After granting port p, port (p+1) mod NUM_PORTS has highest priority.
- Arithmetic:
  - add overflow: carry out of bit DATA_W-1 → resp 2. Data is 0, or all-ones if SATURATE=1.
  - sub underflow: op2 > op1 → resp 2. Data is 0 in both modes.
  - Shifts always give resp 1. Shifted-out bits are lost, zero fill.
  - Invalid command → resp 2, data 0, in both modes.
  - Equality at the boundary is not an error: op1 = op2 on sub gives resp 1, data 0.
- Reset:
  - All out_resp and out_data are 0.
  - All ports go to IDLE and the pointer goes to 0.
  - Reset asserted mid-request, in any state, discards that request; no response ever appears for it.

## Timing
- Cycle 0: cmd+op1 sampled. Cycle 1: op2 sampled. Cycle 2: earliest grant.
- Response for a request granted in cycle k is visible during cycle k+1 only, as a one-cycle pulse. Outside pulses, out_resp and out_data are 0.
- Minimum latency: the response is visible in cycle 3.
- With all ports contending, the worst case is cycle 2+NUM_PORTS.
- A port may present its next command in the same cycle its response is visible; it is accepted.
- Responses of different ports may never overlap in the same cycle; at most one port pulses per cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Defaults apply (NUM_PORTS=4, DATA_W=32) unless a scenario states otherwise.
1. Port 1: add 0x1 + 0x1FFFFFFF, then add 0x1FFFFFFF + 0x1FFFFFFF → resp 1 with 0x20000000 in cycle 3, then resp 1 with 0x3FFFFFFE.
2. Port 1: add 0xFFFFFFFF + 0x1.
   - SATURATE=0 → resp 2, data 0.
   - SATURATE=1 → resp 2, data 0xFFFFFFFF.
   - Port 1: sub 0x1 − 0xF → resp 2, data 0.
3. Port 1: cmd 3, then cmd 4, then cmd 5 with 0x1 shift 31 → resp 2 data 0, resp 2 data 0, then resp 1 data 0x80000000.
4. Contention:
   - All four ports issue add k + 0 in the same cycle → one pulse each in cycles 3, 4, 5, 6 in port order 1..4.
   - Ports 2 and 3 then issue back-to-back continuously → their grants alternate, and neither waits more than one slot.
5. Port 1 issues a new cmd while in PEND → that cmd produces no response, and the original result is unchanged. Reset asserted in cycle 1 of a request → all outputs 0 and no response ever appears.
6. NUM_PORTS=2, DATA_W=8: add 0xFF + 0x01 → resp 2; sub 0x05 − 0x05 → resp 1, data 0x00; cmd 6 with 0x80 shift 7 → resp 1, data 0x01.
